// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode values, ALU select
// codes, FSM state encoding, decoded-control record and counter sizing helper.
package ctrl_pkg;

  localparam logic [3:0] OPC_ADD    = 4'd0;
  localparam logic [3:0] OPC_SUB    = 4'd1;
  localparam logic [3:0] OPC_MUL    = 4'd4;
  localparam logic [3:0] OPC_DIV    = 4'd5;
  localparam logic [3:0] OPC_OUT_WR = 4'd6;
  localparam logic [3:0] OPC_OUT_RD = 4'd7;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] op_select;
    logic       sub;
    logic       we;
    logic       re;
    logic       alu;
    logic       multi;
    logic       illegal;
  } dec_t;

  // Width of the latency counter: enough for the longest op, never zero.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m > 1) begin
      return $clog2(m);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode onto ALU select, subtract,
// output-register strobes, multi-cycle and illegal indications.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  // Opcode to control-field lookup; unlisted opcodes are reported illegal (NOP).
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_ADD: begin
        dec.op_select = ALU_ADD;
        dec.alu       = 1'b1;
      end
      OPC_SUB: begin
        dec.op_select = ALU_SUB;
        dec.sub       = 1'b1;
        dec.alu       = 1'b1;
      end
      OPC_MUL: begin
        dec.op_select = ALU_MUL;
        dec.alu       = 1'b1;
        dec.multi     = 1'b1;
      end
      OPC_DIV: begin
        dec.op_select = ALU_DIV;
        dec.alu       = 1'b1;
        dec.multi     = 1'b1;
      end
      OPC_OUT_WR: begin
        dec.we = 1'b1;
      end
      OPC_OUT_RD: begin
        dec.re = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Registered control sequencer: accepts instructions over valid/ready, drives
// ALU and output-register control one cycle after transfer, and holds control
// while stalling fetch for multi-cycle MUL/DIV.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (sticky illegal-opcode trap).
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int IDX_W      = 5,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic [2:0]         op_select,
  output logic               sub,
  output logic               op_valid,
  output logic               op_done,
  output logic               write_enable,
  output logic               read_enable,
  output logic [IDX_W-1:0]   output_index,
  output logic               busy,
  output logic               illegal
);

  localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);
  // Count loaded on entry to WAIT: WAIT runs CYCLES-2 down to 0.
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : CNT_W'(0);
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_CYCLES > 1) ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(0);
  localparam logic MUL_LONG = (MUL_CYCLES > 1);
  localparam logic DIV_LONG = (DIV_CYCLES > 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               long_q, long_d;
  logic [2:0]         op_select_q, op_select_d;
  logic               sub_q, sub_d;
  logic               op_valid_q, op_valid_d;
  logic               op_done_q, op_done_d;
  logic               we_q, we_d;
  logic               re_q, re_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               busy_q, busy_d;
  logic               illegal_q, illegal_d;

  dec_t               dec_s;
  logic               ready_s;
  logic               xfer_s;
  logic               is_div_s;
  logic               new_long_s;
  logic [CNT_W-1:0]   new_load_s;
  logic               instr_unused_s;

  ctrl_decode u_decode (
    .opcode (instruction[INSTR_W-1 -: 4]),
    .dec    (dec_s)
  );

  // Middle instruction bits carry no meaning for the sequencer.
  assign instr_unused_s = ^{instruction, dec_s.illegal};

  assign is_div_s   = (dec_s.op_select == ALU_DIV);
  assign new_long_s = dec_s.multi & (is_div_s ? DIV_LONG : MUL_LONG);
  assign new_load_s = is_div_s ? DIV_LOAD : MUL_LOAD;
  assign xfer_s     = instr_valid & ready_s;

  // Accept in IDLE or after a single-cycle op; never during reset or a trap.
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else if (illegal_q) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  ready_s = 1'b1;
        ST_ISSUE: ready_s = ~long_q;
        default:  ready_s = 1'b0;
      endcase
    end
  end

  // Next-state, latency counter and next registered control outputs.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    long_d      = long_q;
    op_select_d = 3'b000;
    sub_d       = 1'b0;
    op_valid_d  = 1'b0;
    op_done_d   = 1'b0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    index_d     = {IDX_W{1'b0}};
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q | (xfer_s & dec_s.illegal);
`else
    illegal_d   = 1'b0;
`endif
    if (xfer_s) begin
      state_d     = ST_ISSUE;
      op_select_d = dec_s.op_select;
      sub_d       = dec_s.sub;
      we_d        = dec_s.we;
      re_d        = dec_s.re;
      op_valid_d  = dec_s.alu;
      op_done_d   = dec_s.alu & ~new_long_s;
      long_d      = new_long_s;
      count_d     = new_long_s ? new_load_s : CNT_W'(0);
      if (dec_s.we | dec_s.re) begin
        index_d = instruction[IDX_W-1:0];
      end else begin
        index_d = {IDX_W{1'b0}};
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ISSUE: begin
          if (long_q) begin
            state_d     = ST_WAIT;
            op_select_d = op_select_q;
            sub_d       = sub_q;
            op_done_d   = (count_q == CNT_W'(0));
          end else begin
            state_d = ST_IDLE;
            long_d  = 1'b0;
          end
        end
        ST_WAIT: begin
          if (count_q == CNT_W'(0)) begin
            state_d = ST_IDLE;
            long_d  = 1'b0;
          end else begin
            count_d     = count_q - CNT_W'(1);
            op_select_d = op_select_q;
            sub_d       = sub_q;
            op_done_d   = (count_q == CNT_W'(1));
          end
        end
        default: begin
          state_d = ST_IDLE;
          long_d  = 1'b0;
          count_d = CNT_W'(0);
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= CNT_W'(0);
      long_q      <= 1'b0;
      op_select_q <= 3'b000;
      sub_q       <= 1'b0;
      op_valid_q  <= 1'b0;
      op_done_q   <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      index_q     <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      long_q      <= long_d;
      op_select_q <= op_select_d;
      sub_q       <= sub_d;
      op_valid_q  <= op_valid_d;
      op_done_q   <= op_done_d;
      we_q        <= we_d;
      re_q        <= re_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready  = ready_s;
  assign op_select    = op_select_q;
  assign sub          = sub_q;
  assign op_valid     = op_valid_q;
  assign op_done      = op_done_q;
  assign write_enable = we_q;
  assign read_enable  = re_q;
  assign output_index = index_q;
  assign busy         = busy_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a cycle-count model.
module tb_control_sequencer;

  localparam int INSTR_W = 16;
  localparam int IDX_W   = 5;
  localparam int MULC    = 3;
  localparam int DIVC    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic [2:0]        op_select;
  logic              sub, op_valid, op_done, write_enable, read_enable, busy, illegal;
  logic [IDX_W-1:0]  output_index;

  control_sequencer #(
    .INSTR_W    (INSTR_W),
    .IDX_W      (IDX_W),
    .MUL_CYCLES (MULC),
    .DIV_CYCLES (DIVC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .op_select    (op_select),
    .sub          (sub),
    .op_valid     (op_valid),
    .op_done      (op_done),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .output_index (output_index),
    .busy         (busy),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  // Output bundle: {op_select[14:12], sub[11], op_valid[10], op_done[9],
  // we[8], re[7], index[6:2], busy[1], illegal[0]}
  wire [14:0] dut_out = {op_select, sub, op_valid, op_done, write_enable,
                         read_enable, output_index, busy, illegal};

  int tests = 0;
  int fails = 0;

  // Reference model: cycles still owed by a multi-cycle op, plus held fields.
  int         m_left = 0;
  logic [2:0] m_op   = 3'b000;
  logic       m_sub  = 1'b0;
  logic       m_alu  = 1'b0;
  logic       m_trap = 1'b0;
  logic [14:0] m_out = 15'd0;

  typedef struct {
    logic        r;
    logic        v;
    logic [15:0] ins;
    logic        exp_rdy;
    logic [14:0] exp_out;
  } vec_t;

  vec_t        vecs[9];
  logic        rs[6];
  logic [14:0] os[6];
  logic        rdy_tmp;
  logic [14:0] out_tmp;
  int          cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int op_cycles(input logic [3:0] opc);
    if (opc == 4'd4) return MULC;
    else if (opc == 4'd5) return DIVC;
    else return 1;
  endfunction

  function automatic logic is_illegal(input logic [3:0] opc);
    return (opc == 4'd2) || (opc == 4'd3) || (opc >= 4'd8);
  endfunction

  // One clock: drive inputs, check ready mid-cycle, advance model, check outputs.
  task automatic cycle(input logic r, input logic v, input logic [15:0] ins,
                       output logic rdy_seen, output logic [14:0] out_seen);
    logic       mr;
    logic [3:0] opc;
    int         cyc;
    rst = r; instr_valid = v; instruction = ins;
    #4;
    mr = !r && !m_trap && (m_left == 0);
    check("instr_ready", 32'(instr_ready), 32'(mr));
    rdy_seen = instr_ready;
    @(posedge clk);
    opc = ins[15:12];
    if (r) begin
      m_left = 0; m_trap = 1'b0; m_out = 15'd0;
    end else if (v && mr) begin
      cyc   = op_cycles(opc);
      m_alu = (opc == 4'd0) || (opc == 4'd1) || (opc == 4'd4) || (opc == 4'd5);
      m_op  = (opc == 4'd1) ? 3'b001 : (opc == 4'd4) ? 3'b100 : (opc == 4'd5) ? 3'b101 : 3'b000;
      m_sub = (opc == 4'd1);
      m_left = (cyc > 1) ? cyc : 0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      m_trap = m_trap | is_illegal(opc);
`endif
      m_out = {m_op, m_sub, m_alu, m_alu && (cyc == 1), opc == 4'd6, opc == 4'd7,
               ((opc == 4'd6) || (opc == 4'd7)) ? ins[4:0] : 5'd0, 1'b1, m_trap};
    end else if (m_left > 1) begin
      m_left--;
      m_out = {m_op, m_sub, 1'b0, m_alu && (m_left == 1), 2'b00, 5'd0, 1'b1, m_trap};
    end else begin
      m_left = 0;
      m_out = {14'd0, m_trap};
    end
    #1;
    check("outputs", 32'(dut_out), 32'(m_out));
    out_seen = dut_out;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instruction = 16'h0000;

    // Directed table: reset, back-to-back ops, index handling, dropped valid.
    vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 15'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h4000, 1'b0, 15'h0000};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 1'b1, 15'h0602};
    vecs[3] = '{1'b0, 1'b1, 16'h1000, 1'b1, 15'h1E02};
    vecs[4] = '{1'b0, 1'b1, 16'h6007, 1'b1, 15'h011E};
    vecs[5] = '{1'b0, 1'b1, 16'h701F, 1'b1, 15'h00FE};
    vecs[6] = '{1'b0, 1'b1, 16'h0FE0, 1'b1, 15'h0602};
    vecs[7] = '{1'b0, 1'b0, 16'h701F, 1'b1, 15'h0000};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 15'h0000};
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].ins, rdy_tmp, out_tmp);
      check($sformatf("vec%0d_ready", i), 32'(rdy_tmp), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_out", i), 32'(out_tmp), 32'(vecs[i].exp_out));
    end

    // MUL followed by an ADD held valid: 3 held cycles, then the ADD issues.
    cycle(1'b0, 1'b1, 16'h4000, rs[0], os[0]);
    for (int i = 1; i < 5; i++) cycle(1'b0, 1'b1, 16'h0000, rs[i], os[i]);
    cnt = 0;
    for (int i = 0; i < 5; i++) if (os[i][14:12] == 3'b100) cnt++;
    check("mul_held_cycles", 32'(cnt), 32'd3);
    cnt = 0;
    for (int i = 1; i < 5; i++) if (!rs[i]) cnt++;
    check("mul_ready_low_cycles", 32'(cnt), 32'd3);
    check("mul_done_last_held", 32'({os[0][9], os[1][9], os[2][9]}), 32'b001);
    check("add_after_mul", 32'({os[4][14:12], os[4][10]}), 32'b0001);
    cycle(1'b0, 1'b0, 16'h0000, rdy_tmp, out_tmp);

    // DIV aborted by reset on its 4th held cycle.
    cycle(1'b0, 1'b1, 16'h5000, rs[0], os[0]);
    cnt = os[0][9] ? 1 : 0;
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, rs[i], os[i]);
      if (os[i][9]) cnt++;
    end
    check("div_held_op", 32'(os[3][14:12]), 32'b101);
    cycle(1'b1, 1'b1, 16'h0000, rs[4], os[4]);
    if (os[4][9]) cnt++;
    check("div_abort_out", 32'(os[4]), 32'd0);
    check("div_abort_no_done", 32'(cnt), 32'd0);
    cycle(1'b0, 1'b1, 16'h1000, rs[5], os[5]);
    check("after_abort_sub", 32'(os[5][14:11]), 32'b0011);
    cycle(1'b0, 1'b0, 16'h0000, rdy_tmp, out_tmp);

    // Opcode 0xA: trap or silent NOP depending on configuration.
    cycle(1'b0, 1'b1, 16'hA000, rs[0], os[0]);
    for (int i = 1; i < 4; i++) cycle(1'b0, 1'b1, 16'h0000, rs[i], os[i]);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("trap_illegal", 32'(os[3][0]), 32'd1);
    check("trap_ready_stuck", 32'({rs[1], rs[2], rs[3]}), 32'd0);
`else
    check("nop_illegal", 32'(os[0][0]), 32'd0);
    check("nop_out", 32'(os[0]), 32'h2);
    check("nop_ready", 32'(rs[1]), 32'd1);
`endif
    cycle(1'b1, 1'b0, 16'h0000, rdy_tmp, out_tmp);
    cycle(1'b0, 1'b0, 16'h0000, rdy_tmp, out_tmp);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        rr, vv;
      logic [15:0] ii;
      rr = ($urandom_range(63) == 0);
      vv = $urandom_range(1) == 1;
      ii = 16'($urandom);
      cycle(rr, vv, ii, rdy_tmp, out_tmp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
